// File: rtl/fp_add_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_add_pipe : 3-stage IEEE-754 add/subtract, RNE, DAZ/FTZ, valid/ready     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [EXP_W+MAN_W:0]     i_a,
  input  logic [EXP_W+MAN_W:0]     i_b,
  input  logic                     i_sub,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [EXP_W+MAN_W:0]     o_result,
  output logic [3:0]               o_flags
);

  localparam int c_w  = 1 + EXP_W + MAN_W;
  localparam int c_n  = MAN_W + 4;
  localparam int c_xw = EXP_W + 2;
  localparam logic [c_w-1:0] c_qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [c_xw-1:0] c_exp_max  = c_xw'((1 << EXP_W) - 1);
  localparam logic signed [c_xw-1:0] c_exp_one  = c_xw'(1);
  localparam logic signed [c_xw-1:0] c_exp_zero = '0;

  logic w_advance;
  assign w_advance = !o_valid || i_ready;
  assign o_ready   = w_advance;

  // Stage 1: classify, swap, align
  logic                    w_a_sign, w_b_sign;
  logic [EXP_W-1:0]        w_a_exp, w_b_exp;
  logic [MAN_W-1:0]        w_a_frac, w_b_frac;
  logic                    w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic [EXP_W+MAN_W-1:0]  w_a_mag, w_b_mag, w_big_mag, w_small_mag;
  logic                    w_swap, w_big_sign;
  logic [EXP_W-1:0]        w_diff;
  logic [c_n-1:0]          w_big_sig, w_small_sig, w_aligned;
  logic [2*c_n-1:0]        w_wide;
  logic                    w_spec;
  logic [c_w-1:0]          w_spec_res;
  logic [3:0]              w_spec_flags;

  assign w_a_sign = i_a[c_w-1];
  assign w_b_sign = i_b[c_w-1] ^ i_sub;
  assign w_a_exp  = i_a[c_w-2:MAN_W];
  assign w_b_exp  = i_b[c_w-2:MAN_W];
  assign w_a_frac = i_a[MAN_W-1:0];
  assign w_b_frac = i_b[MAN_W-1:0];

  assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
  assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
  assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
  assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);
  assign w_a_snan = w_a_nan && !w_a_frac[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_b_frac[MAN_W-1];

  // Subnormal inputs collapse to zero magnitude, keeping their sign
  assign w_a_mag     = (w_a_exp == '0) ? '0 : {w_a_exp, w_a_frac};
  assign w_b_mag     = (w_b_exp == '0) ? '0 : {w_b_exp, w_b_frac};
  assign w_swap      = w_b_mag > w_a_mag;
  assign w_big_mag   = w_swap ? w_b_mag : w_a_mag;
  assign w_small_mag = w_swap ? w_a_mag : w_b_mag;
  assign w_big_sign  = w_swap ? w_b_sign : w_a_sign;

  assign w_big_sig   = {(w_big_mag[EXP_W+MAN_W-1:MAN_W] != '0), w_big_mag[MAN_W-1:0], 3'b000};
  assign w_small_sig = {(w_small_mag[EXP_W+MAN_W-1:MAN_W] != '0), w_small_mag[MAN_W-1:0], 3'b000};
  assign w_diff      = w_big_mag[EXP_W+MAN_W-1:MAN_W] - w_small_mag[EXP_W+MAN_W-1:MAN_W];
  assign w_wide      = {w_small_sig, {c_n{1'b0}}} >> w_diff;

  always_comb begin
    if (32'(w_diff) >= 32'(MAN_W + 3))
      w_aligned = {{(c_n-1){1'b0}}, |w_small_sig};
    else
      w_aligned = {w_wide[2*c_n-1:c_n+1], w_wide[c_n] | (|w_wide[c_n-1:0])};
  end

  always_comb begin
    w_spec       = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
    w_spec_res   = c_qnan;
    w_spec_flags = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      w_spec_flags = {(w_a_snan || w_b_snan), 3'b000};
    end else if (w_a_inf && w_b_inf && (w_a_sign != w_b_sign)) begin
      w_spec_flags = 4'b1000;
    end else if (w_a_inf) begin
      w_spec_res = {w_a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_res = {w_b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic                    r_s1_valid, r_s1_sign, r_s1_sub, r_s1_spec;
  logic signed [c_xw-1:0]  r_s1_exp;
  logic [c_n-1:0]          r_s1_big, r_s1_small;
  logic [c_w-1:0]          r_s1_spec_res;
  logic [3:0]              r_s1_spec_flags;

  // Stage 2: magnitude add/subtract (big >= small, never negative)
  logic [c_n:0] w_sum;
  assign w_sum = r_s1_sub ? ({1'b0, r_s1_big} - {1'b0, r_s1_small})
                          : ({1'b0, r_s1_big} + {1'b0, r_s1_small});

  logic                    r_s2_valid, r_s2_sign, r_s2_sub, r_s2_spec;
  logic signed [c_xw-1:0]  r_s2_exp;
  logic [c_n:0]            r_s2_sum;
  logic [c_w-1:0]          r_s2_spec_res;
  logic [3:0]              r_s2_spec_flags;

  // Stage 3: normalise, round, pack
  logic signed [c_xw-1:0]  w_lz, w_exp_n, w_exp_r;
  logic                    w_found;
  logic [c_n-1:0]          w_norm;
  logic                    w_round_up, w_inexact;
  logic [MAN_W+1:0]        w_rounded;
  logic [MAN_W-1:0]        w_frac_r;
  logic [c_w-1:0]          w_res;
  logic [3:0]              w_flags;

  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = c_n - 1; i >= 0; i--) begin
      if (!w_found && r_s2_sum[i]) begin
        w_lz    = c_xw'(c_n - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    if (r_s2_sum[c_n]) begin
      // Carry-out: fold the dropped bit into sticky
      w_norm  = {r_s2_sum[c_n:2], r_s2_sum[1] | r_s2_sum[0]};
      w_exp_n = r_s2_exp + c_exp_one;
    end else begin
      w_norm  = r_s2_sum[c_n-1:0] << w_lz;
      w_exp_n = r_s2_exp - w_lz;
    end
    w_round_up = w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
    w_inexact  = |w_norm[2:0];
    w_rounded  = {1'b0, w_norm[c_n-1:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
    if (w_rounded[MAN_W+1]) begin
      w_exp_r  = w_exp_n + c_exp_one;
      w_frac_r = w_rounded[MAN_W:1];
    end else begin
      w_exp_r  = w_exp_n;
      w_frac_r = w_rounded[MAN_W-1:0];
    end

    w_res   = {r_s2_sign, w_exp_r[EXP_W-1:0], w_frac_r};
    w_flags = {3'b000, w_inexact};
    if (r_s2_spec) begin
      w_res   = r_s2_spec_res;
      w_flags = r_s2_spec_flags;
    end else if (r_s2_sum == '0) begin
      w_res   = {r_s2_sign && !r_s2_sub, {(c_w-1){1'b0}}};
      w_flags = 4'b0000;
    end else if (w_exp_r >= c_exp_max) begin
      w_res   = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags = 4'b0101;
    end else if (w_exp_r <= c_exp_zero) begin
      w_res   = {r_s2_sign, {(c_w-1){1'b0}}};
      w_flags = 4'b0011;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid      <= 1'b0;
      r_s1_sign       <= 1'b0;
      r_s1_sub        <= 1'b0;
      r_s1_spec       <= 1'b0;
      r_s1_exp        <= '0;
      r_s1_big        <= '0;
      r_s1_small      <= '0;
      r_s1_spec_res   <= '0;
      r_s1_spec_flags <= '0;
      r_s2_valid      <= 1'b0;
      r_s2_sign       <= 1'b0;
      r_s2_sub        <= 1'b0;
      r_s2_spec       <= 1'b0;
      r_s2_exp        <= '0;
      r_s2_sum        <= '0;
      r_s2_spec_res   <= '0;
      r_s2_spec_flags <= '0;
      o_valid         <= 1'b0;
      o_result        <= '0;
      o_flags         <= '0;
    end else if (w_advance) begin
      r_s1_valid      <= i_valid;
      r_s1_sign       <= w_big_sign;
      r_s1_sub        <= w_a_sign ^ w_b_sign;
      r_s1_spec       <= w_spec;
      r_s1_exp        <= {2'b00, w_big_mag[EXP_W+MAN_W-1:MAN_W]};
      r_s1_big        <= w_big_sig;
      r_s1_small      <= w_aligned;
      r_s1_spec_res   <= w_spec_res;
      r_s1_spec_flags <= w_spec_flags;
      r_s2_valid      <= r_s1_valid;
      r_s2_sign       <= r_s1_sign;
      r_s2_sub        <= r_s1_sub;
      r_s2_spec       <= r_s1_spec;
      r_s2_exp        <= r_s1_exp;
      r_s2_sum        <= w_sum;
      r_s2_spec_res   <= r_s1_spec_res;
      r_s2_spec_flags <= r_s1_spec_flags;
      o_valid         <= r_s2_valid;
      o_result        <= w_res;
      o_flags         <= w_flags;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_add_pipe : directed vectors for fp_add_pipe at EXP_W=8, MAN_W=23     |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_fp_add_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  int checks = 0;
  int failures = 0;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_sub    (i_sub),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flags  (o_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Entered at a negedge; drives one op, checks latency, result and flags
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] er, input logic [3:0] ef, input string tag);
    int lat;
    i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1; i_ready = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    check({tag, ".result"}, o_result, er);
    check({tag, ".flags"}, 32'(o_flags), {28'd0, ef});
    @(negedge i_clk);
  endtask

  logic [31:0] q_a   [0:6];
  logic [31:0] q_res [0:6];

  initial begin
    int cyc, sent, got, held, stall_seen, extra;
    logic [31:0] prev;

    // Reset state
    #1;
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.result", o_result, 32'd0);
    check("rst.flags", 32'(o_flags), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst.ready", 32'(o_ready), 32'd1);

    do_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "add_1_2");
    do_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie_even");
    do_op(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, "rne_up");
    do_op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, "tie_odd");
    do_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "sub_equal");
    do_op(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000, "neg_plus_pos");
    do_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "negz_negz");
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, "overflow");
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, "inf_m_inf");
    do_op(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011, "underflow");
    do_op(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, "snan");
    do_op(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, "qnan");
    do_op(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000, "fin_p_ninf");

    // Back-to-back burst with downstream stalled for cycles 2..8
    q_a[0] = 32'h3F800000; q_res[0] = 32'h40000000;
    q_a[1] = 32'h40000000; q_res[1] = 32'h40400000;
    q_a[2] = 32'h40400000; q_res[2] = 32'h40800000;
    q_a[3] = 32'h40800000; q_res[3] = 32'h40A00000;
    q_a[4] = 32'h40A00000; q_res[4] = 32'h40C00000;
    q_a[5] = 32'h40C00000; q_res[5] = 32'h40E00000;
    q_a[6] = 32'h0;        q_res[6] = 32'h0;
    cyc = 0; sent = 0; got = 0; held = 0; stall_seen = 0; prev = '0;
    while (got < 6 && cyc < 60) begin
      i_ready = !(cyc >= 2 && cyc <= 8);
      i_valid = (sent < 6);
      i_a     = q_a[sent];
      i_b     = 32'h3F800000;
      i_sub   = 1'b0;
      #1;
      if (!o_ready) stall_seen = 1;
      if (o_valid && i_ready) begin
        check($sformatf("burst.res%0d", got), o_result, q_res[got]);
        got++;
      end
      if (o_valid && !i_ready) begin
        if (held != 0) check("burst.stable", o_result, prev);
        held = 1;
        prev = o_result;
      end else begin
        held = 0;
      end
      if (i_valid && o_ready) sent++;
      @(negedge i_clk);
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    check("burst.sent", 32'(sent), 32'd6);
    check("burst.got", 32'(got), 32'd6);
    check("burst.stall", 32'(stall_seen), 32'd1);
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (o_valid) extra++;
      @(negedge i_clk);
    end
    check("burst.no_dup", 32'(extra), 32'd0);

    // Asynchronous reset with three ops in flight
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_a = q_a[k]; i_b = 32'h3F800000; i_sub = 1'b0; i_valid = 1'b1;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    #1;
    check("inflight.valid", 32'(o_valid), 32'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(o_valid), 32'd0);
    check("midrst.result", o_result, 32'd0);
    check("midrst.flags", 32'(o_flags), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (o_valid) extra++;
      @(negedge i_clk);
    end
    check("midrst.no_partial", 32'(extra), 32'd0);
    do_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
